// File: rtl/t07_bus_pkg.sv
// -----------------------------------------------------------------------------
// t07_bus_pkg
// Shared types and constants for the t07 CPU-to-Wishbone bridge.
//   rwi_t          : CPU request encoding carried on cpu_rwi_i
//   bridge_state_t : bridge sequencer states
//   req_t          : request fields captured when a CPU request is accepted
//   word_align()   : clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package t07_bus_pkg;

  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_WRITE = 2'b01,
    RWI_READ  = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } bridge_state_t;

  typedef struct packed {
    rwi_t        kind;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int          TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [31:0] DEAD_WORD_DEFAULT      = 32'hBAD0_BAD0;

  // Wishbone addresses words; the CPU's byte offset is dropped on the bus.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/t07_cpu_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// t07_cpu_bus_bridge_if
// Single-beat Wishbone-classic bus between the bridge and the interconnect.
//   master modport : the bridge (drives cyc/stb/we/adr/dat/sel)
//   slave modport  : the SRAM/MMIO interconnect (drives dat_i/ack/err)
// Signal names keep the bridge-side _o/_i suffixes so both ends read the same.
// -----------------------------------------------------------------------------
interface t07_cpu_bus_bridge_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/t07_bus_timeout.sv
// -----------------------------------------------------------------------------
// t07_bus_timeout
// Counts cycles spent waiting for a slave response.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : force count to zero (takes priority over en_i)
//   en_i       : count this cycle
//   expire_o   : high while enabled and the count has reached TIMEOUT_CYCLES-1
// The count saturates at the expiry value so it can never wrap to zero.
// -----------------------------------------------------------------------------
module t07_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last  = (cnt_q == LAST);
  assign expire_o = en_i && at_last;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/t07_cpu_bus_bridge.sv
// -----------------------------------------------------------------------------
// t07_cpu_bus_bridge
// Turns each t07 CPU external request into one single-beat Wishbone-classic
// transaction, with an ack timeout so a hung slave cannot stall the core.
//   clk, rst      : clock, asynchronous active-high reset
//   cpu_rwi_i     : 00 idle, 01 write, 10 read, 11 instruction fetch
//   cpu_addr_i    : byte address from the CPU
//   cpu_wdata_i   : store data from the CPU
//   cpu_busy_o    : high while a request is outstanding (combinational in IDLE)
//   cpu_inst_o    : last fetched instruction (exInst)
//   cpu_rdata_o   : last load data (memData_in)
//   wb            : Wishbone master port
//   timeout_o     : one-cycle pulse (in DONE) after a timeout abort
//   bus_err_o     : sticky error flag, set by err or timeout, cleared by rst
// Sequence: IDLE -> REQ (1 cycle) -> WAIT (until ack/err/timeout) -> DONE
// (1 cycle, busy low) -> IDLE.
// -----------------------------------------------------------------------------
module t07_cpu_bus_bridge
  import t07_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [31:0] DEAD_WORD      = DEAD_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cpu_rwi_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wdata_i,
  output logic                  cpu_busy_o,
  output logic [31:0]           cpu_inst_o,
  output logic [31:0]           cpu_rdata_o,
  t07_cpu_bus_bridge_if.master  wb,
  output logic                  timeout_o,
  output logic                  bus_err_o
);

  bridge_state_t state_q, state_d;
  req_t          req_q, req_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          timeout_q, timeout_d;
  logic          bus_err_q, bus_err_d;

  logic          busy;
  logic          finish;
  logic [31:0]   finish_data;
  logic          active;
  logic          expire;
  rwi_t          cpu_rwi;

  assign cpu_rwi = rwi_t'(cpu_rwi_i);

  // Counter is cleared in REQ so WAIT always starts at zero.
  t07_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == REQ),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    inst_d      = inst_q;
    rdata_d     = rdata_q;
    timeout_d   = 1'b0;
    bus_err_d   = bus_err_q;
    busy        = 1'b0;
    finish      = 1'b0;
    finish_data = wb.wb_dat_i;

    unique case (state_q)
      IDLE: begin
        // Busy rises in the request cycle itself, before any edge.
        busy = (cpu_rwi != RWI_IDLE);
        if (cpu_rwi != RWI_IDLE) begin
          req_d   = '{kind: cpu_rwi, addr: cpu_addr_i, wdata: cpu_wdata_i};
          state_d = REQ;
        end
      end

      REQ: begin
        busy    = 1'b1;
        state_d = WAIT;
      end

      WAIT: begin
        busy = 1'b1;
        // Priority: err beats ack, and ack beats an expiry in the same cycle.
        if (wb.wb_err_i) begin
          finish      = 1'b1;
          finish_data = DEAD_WORD;
          bus_err_d   = 1'b1;
        end else if (wb.wb_ack_i) begin
          finish      = 1'b1;
        end else if (expire) begin
          finish      = 1'b1;
          finish_data = DEAD_WORD;
          bus_err_d   = 1'b1;
          timeout_d   = 1'b1;
        end
      end

      DONE: begin
        // cpu_rwi_i is deliberately ignored here; a held request is picked up
        // in the following IDLE cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Only the register matching the request type is updated; writes return
    // no data, so an aborted write only raises the error flag.
    if (finish) begin
      state_d = DONE;
      if (req_q.kind == RWI_READ) begin
        rdata_d = finish_data;
      end
      if (req_q.kind == RWI_FETCH) begin
        inst_d = finish_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '{kind: RWI_IDLE, addr: '0, wdata: '0};
      inst_q    <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Bus outputs decode directly from the state flop, so an asynchronous reset
  // drops cyc/stb immediately. Outside a transaction the bus is driven to zero.
  assign active       = (state_q == REQ) || (state_q == WAIT);
  assign wb.wb_cyc_o  = active;
  assign wb.wb_stb_o  = active;
  assign wb.wb_we_o   = active && (req_q.kind == RWI_WRITE);
  assign wb.wb_adr_o  = active ? word_align(req_q.addr) : '0;
  assign wb.wb_dat_o  = active ? req_q.wdata : '0;
  assign wb.wb_sel_o  = 4'hF;

  assign cpu_busy_o   = busy;
  assign cpu_inst_o   = inst_q;
  assign cpu_rdata_o  = rdata_q;
  assign timeout_o    = timeout_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_t07_cpu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_t07_cpu_bus_bridge
// Self-checking bench for t07_cpu_bus_bridge. The bench acts as both the CPU
// and the Wishbone slave. A small reference model tracks what the CPU-visible
// registers and the error flag must hold after each request, based only on
// request type and slave response.
// -----------------------------------------------------------------------------
module tb_t07_cpu_bus_bridge;

  localparam int          TO   = 8;
  localparam logic [31:0] DEAD = 32'hBAD0_BAD0;

  typedef enum int {R_ACK, R_ERR, R_BOTH, R_NONE} resp_e;

  logic        clk;
  logic        rst;
  logic [1:0]  cpu_rwi;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic [31:0] cpu_inst;
  logic [31:0] cpu_rdata;
  logic        timeout;
  logic        bus_err;

  t07_cpu_bus_bridge_if wb_if ();

  t07_cpu_bus_bridge #(
    .TIMEOUT_CYCLES (TO),
    .DEAD_WORD      (DEAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rwi_i   (cpu_rwi),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_busy_o  (cpu_busy),
    .cpu_inst_o  (cpu_inst),
    .cpu_rdata_o (cpu_rdata),
    .wb          (wb_if),
    .timeout_o   (timeout),
    .bus_err_o   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] exp_inst;
  logic [31:0] exp_rdata;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_inst  = '0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  // One complete CPU request. The slave responds after wait_n WAIT cycles
  // (ignored for R_NONE). With hold set, the CPU keeps rwi asserted through
  // DONE and only drops it in the following IDLE cycle before the edge.
  task automatic run_txn(input logic [1:0] kind, input logic [31:0] a,
                         input logic [31:0] d, input int wait_n,
                         input resp_e resp, input logic [31:0] sdata,
                         input bit hold);
    int waits;
    bit fired;
    @(negedge clk);
    cpu_rwi   = kind;
    cpu_addr  = a;
    cpu_wdata = d;
    #1 check("busy_in_request_cycle", cpu_busy, 1'b1);

    @(negedge clk);  // REQ
    if (!hold) cpu_rwi = 2'b00;
    check("req_cyc", wb_if.wb_cyc_o, 1'b1);
    check("req_stb", wb_if.wb_stb_o, 1'b1);
    check("req_we",  wb_if.wb_we_o, (kind == 2'b01));
    check("req_adr", wb_if.wb_adr_o, a & 32'hFFFF_FFFC);
    check("req_sel", wb_if.wb_sel_o, 4'hF);
    check("req_busy", cpu_busy, 1'b1);
    if (kind == 2'b01) check("req_dat", wb_if.wb_dat_o, d);

    waits = 0;
    fired = 1'b0;
    forever begin
      @(negedge clk);
      wb_if.wb_ack_i = 1'b0;
      wb_if.wb_err_i = 1'b0;
      if (fired || !wb_if.wb_cyc_o || waits > TO + 2) break;
      if (waits == 0) begin
        check("wait_adr_stable", wb_if.wb_adr_o, a & 32'hFFFF_FFFC);
        check("wait_busy", cpu_busy, 1'b1);
      end
      if (resp != R_NONE && waits == wait_n) begin
        wb_if.wb_dat_i = sdata;
        wb_if.wb_ack_i = (resp == R_ACK) || (resp == R_BOTH);
        wb_if.wb_err_i = (resp == R_ERR) || (resp == R_BOTH);
        fired = 1'b1;
      end
      waits++;
    end

    // Reference model: outcome depends only on type and response.
    if (resp == R_ACK) begin
      if (kind == 2'b10) exp_rdata = sdata;
      if (kind == 2'b11) exp_inst  = sdata;
    end else begin
      exp_err = 1'b1;
      if (kind == 2'b10) exp_rdata = DEAD;
      if (kind == 2'b11) exp_inst  = DEAD;
    end

    // Now in DONE.
    if (resp == R_NONE) check("timeout_wait_cycles", waits, TO);
    check("done_cyc", wb_if.wb_cyc_o, 1'b0);
    check("done_stb", wb_if.wb_stb_o, 1'b0);
    check("done_busy", cpu_busy, 1'b0);
    check("done_timeout", timeout, (resp == R_NONE));
    check("done_bus_err", bus_err, exp_err);
    check("done_inst", cpu_inst, exp_inst);
    check("done_rdata", cpu_rdata, exp_rdata);

    if (hold) begin
      @(negedge clk);  // IDLE with request still held: busy returns at once
      check("idle_busy_held", cpu_busy, 1'b1);
      check("idle_cyc_held", wb_if.wb_cyc_o, 1'b0);
      cpu_rwi = 2'b00;
      #1 check("idle_busy_dropped", cpu_busy, 1'b0);
    end else begin
      @(negedge clk);  // IDLE
      check("idle_timeout_low", timeout, 1'b0);
    end
  endtask

  initial begin
    cpu_rwi        = 2'b00;
    cpu_addr       = '0;
    cpu_wdata      = '0;
    wb_if.wb_dat_i = '0;
    wb_if.wb_ack_i = 1'b0;
    wb_if.wb_err_i = 1'b0;
    model_reset();

    // Reset then idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_cyc", wb_if.wb_cyc_o, 1'b0);
    check("rst_stb", wb_if.wb_stb_o, 1'b0);
    check("rst_we",  wb_if.wb_we_o, 1'b0);
    check("rst_adr", wb_if.wb_adr_o, 32'h0);
    check("rst_dat", wb_if.wb_dat_o, 32'h0);
    check("rst_sel", wb_if.wb_sel_o, 4'hF);
    check("rst_busy", cpu_busy, 1'b0);
    check("rst_inst", cpu_inst, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);

    // Fetch with a one-wait slave, request held through DONE.
    run_txn(2'b11, 32'h0000_0104, $urandom, 1, R_ACK, 32'h00A0_0093, 1'b1);
    // Unaligned write, zero-wait slave; load data must not change.
    run_txn(2'b01, 32'h2000_0003, 32'hDEAD_BEEF, 0, R_ACK, $urandom, 1'b0);
    // Ack in the very cycle the counter expires: ack wins.
    run_txn(2'b10, 32'h1000_0010, $urandom, TO - 1, R_ACK, 32'h1234_5678, 1'b0);
    // Read with no response: timeout abort.
    run_txn(2'b10, 32'h3000_0008, $urandom, 0, R_NONE, '0, 1'b0);
    // Ack and err together on a read: err wins, no timeout pulse.
    run_txn(2'b10, 32'h3000_000C, $urandom, 2, R_BOTH, 32'h5555_AAAA, 1'b0);

    // Ack/err outside WAIT are ignored.
    @(negedge clk);
    wb_if.wb_dat_i = 32'hFEED_F00D;
    wb_if.wb_ack_i = 1'b1;
    @(negedge clk);
    wb_if.wb_ack_i = 1'b0;
    check("idle_ack_rdata", cpu_rdata, exp_rdata);
    check("idle_ack_inst", cpu_inst, exp_inst);
    check("idle_ack_cyc", wb_if.wb_cyc_o, 1'b0);

    // Randomized requests.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      resp_e      resp;
      int         r;
      int         wn;
      kind = 2'($urandom_range(1, 3));
      r    = $urandom_range(0, 9);
      resp = (r == 0) ? R_NONE : (r == 1) ? R_ERR : (r == 2) ? R_BOTH : R_ACK;
      wn   = (resp == R_ACK) ? $urandom_range(0, TO - 1) : $urandom_range(0, TO - 2);
      run_txn(kind, $urandom, $urandom, wn, resp, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT, then a late ack.
    @(negedge clk);
    cpu_rwi  = 2'b10;
    cpu_addr = 32'h4000_0000;
    @(negedge clk);  // REQ
    cpu_rwi = 2'b00;
    @(negedge clk);  // WAIT
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_cyc", wb_if.wb_cyc_o, 1'b0);
    check("midrst_stb", wb_if.wb_stb_o, 1'b0);
    check("midrst_busy", cpu_busy, 1'b0);
    check("midrst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wb_if.wb_dat_i = 32'hCAFE_0001;
    wb_if.wb_ack_i = 1'b1;
    @(negedge clk);
    wb_if.wb_ack_i = 1'b0;
    check("late_ack_rdata", cpu_rdata, exp_rdata);
    check("late_ack_busy", cpu_busy, 1'b0);
    check("late_ack_cyc", wb_if.wb_cyc_o, 1'b0);

    // Bridge recovers after reset.
    run_txn(2'b10, 32'h0000_0040, $urandom, 0, R_ACK, 32'h0BAD_CAFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout got=%h exp=%h", 32'h1, 32'h0);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/t07_cpu_bus_bridge.md
Name: t07_cpu_bus_bridge

Overview:
Sits directly downstream of the t07 CPU core. Consumes its external request (rwi, externalMemAddr, exMemData_out) and produces the busy, exInst and memData_in signals the core expects. Converts each CPU request into exactly one single-beat Wishbone-classic transaction toward the SRAM/MMIO interconnect. Adds an ack timeout so a hung slave cannot stall the core forever.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before abort (1..65535)
DEAD_WORD, 32'hBAD0_BAD0, data returned on error/timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
cpu_rwi_i  in  2  request type: 00 idle, 01 write, 10 read, 11 instruction fetch
cpu_addr_i  in  32  byte address from CPU
cpu_wdata_i  in  32  store data from CPU
cpu_busy_o  out  1  to CPU busy; high while a request is outstanding
cpu_inst_o  out  32  to CPU exInst; last fetched instruction
cpu_rdata_o  out  32  to CPU memData_in; last load data
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  32  Wishbone address, word aligned ([1:0] forced 0)
wb_dat_o  out  32  Wishbone write data
wb_sel_o  out  4  byte selects, always 4'hF
wb_dat_i  in  32  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
timeout_o  out  1  one-cycle pulse on timeout abort
bus_err_o  out  1  sticky error flag; set by err or timeout, cleared only by rst

Behaviour:
- Reset (async assert, sync deassert at the bridge): state IDLE. All wb_* outputs 0 except wb_sel_o=4'hF. cpu_busy_o=0, cpu_inst_o=0, cpu_rdata_o=0, timeout_o=0, bus_err_o=0, timeout counter 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - cpu_busy_o = (cpu_rwi_i != 00), combinational, so the CPU sees busy in the request cycle.
  - On a nonzero rwi, register addr, wdata and type, then go to REQ.
- REQ (1 cycle): assert cyc, stb, we (type==01), adr, dat. Clear counter. Go to WAIT.
- WAIT:
  - cyc and stb stay high and all captured fields stay stable. Counter increments each cycle.
  - wb_ack_i: drop cyc/stb next edge. On read, cpu_rdata_o<=wb_dat_i. On fetch, cpu_inst_o<=wb_dat_i. Go to DONE.
  - wb_err_i, or counter==TIMEOUT_CYCLES-1 with no ack: drop cyc/stb. Load DEAD_WORD into the target register (writes load nothing). Set bus_err_o. Pulse timeout_o on timeout only. Go to DONE.
  - Simultaneous ack and err: err wins.
  - ack arriving in the same cycle the counter expires: ack wins, no timeout.
- DONE (1 cycle): cpu_busy_o=0, which gives the CPU its busy falling edge. Output data is valid and held. cpu_rwi_i is ignored. Go to IDLE.
- Busy is high in REQ and WAIT.
- Latency: REQ to DONE is 1 + (cycles until ack) cycles. Minimum request-to-busy-low is 3 edges with a zero-wait slave.
- Back-to-back requests: a request held through DONE is accepted on the following IDLE cycle. The CPU must drop or change rwi in DONE to avoid a repeat.
- Data registers hold their value until the next completing transaction of the same type.
- Reset mid-transaction: cyc/stb drop asynchronously and the transaction is abandoned. Slave acks that arrive after reset are ignored in IDLE.
- Any ack or err seen outside WAIT is ignored.

Decomposition:
- Package t07_bus_pkg:
  - rwi_t enum: RWI_IDLE, RWI_WRITE, RWI_READ, RWI_FETCH.
  - bridge_state_t enum: IDLE, REQ, WAIT, DONE.
  - DEAD_WORD default constant.
- Sub-module t07_bus_timeout:
  - Parameterized counter with clear, enable and an expire output.
  - Width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset then idle: rst pulse, rwi=00 for 10 cycles -> all wb_* 0, busy 0, bus_err_o 0.
- Fetch: rwi=11, addr=0x0000_0104, slave acks 2 cycles after stb with 0x00A00093 -> wb_adr_o=0x104, we=0, cpu_inst_o=0x00A00093 in DONE, busy low for exactly 1 cycle.
- Write: rwi=01, addr=0x2000_0003, wdata=0xDEADBEEF, zero-wait ack -> wb_adr_o=0x2000_0000, we=1, dat=0xDEADBEEF, cpu_rdata_o unchanged.
- Timeout: TIMEOUT_CYCLES=8, read with no ack -> cyc drops after 8 WAIT cycles, timeout_o high 1 cycle, cpu_rdata_o=0xBAD0_BAD0, bus_err_o=1 and stays set.
- Error precedence: ack and err asserted in the same cycle on a read -> cpu_rdata_o=DEAD_WORD, bus_err_o=1, timeout_o=0.
- Reset mid-WAIT: read outstanding, assert rst -> cyc/stb 0 immediately. A late ack after release produces no data update and busy stays 0.
